// File: rtl/fetch_sequencer.sv
// Instruction fetch / FETCH-EXEC1-EXEC2 sequencer with delayed-branch PC; optional FETCH_SEQ_RETIRE_COUNT_EN retire counter.
// 3 cycles per instruction minimum; mem_waitrequest holds FETCH, stall holds EXEC2, one extra cycle per wait/stall.
module fetch_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
   parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        mem_waitrequest,
   input  logic [31:0] mem_readdata,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        mem_read,
   output logic [31:0] mem_address,
   output logic [31:0] current_instruction,
   output logic        fetch,
   output logic        exec1,
   output logic        exec2,
   output logic [31:0] pc,
   output logic        active
`ifdef FETCH_SEQ_RETIRE_COUNT_EN
   ,
   output logic [31:0] retired_count
`endif
);

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_EXEC1  = 2'd1,
      S_EXEC2  = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_nxt;
   logic [31:0] ir, ir_nxt;
   logic        pend_vld, pend_vld_nxt;
   logic [31:0] pend_target, pend_target_nxt;
   logic [31:0] commit_pc;
   logic        commit;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= S_FETCH;
         pc          <= RESET_VECTOR;
         ir          <= 32'd0;
         pend_vld    <= 1'b0;
         pend_target <= 32'd0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         ir          <= ir_nxt;
         pend_vld    <= pend_vld_nxt;
         pend_target <= pend_target_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      ir_nxt          = ir;
      pend_vld_nxt    = pend_vld;
      pend_target_nxt = pend_target;
      commit          = 1'b0;
      // A pending redirect is consumed by the delay-slot instruction's commit.
      commit_pc       = pend_vld ? pend_target : pc + 32'd4;
      case (state)
         S_FETCH: begin
            if (!mem_waitrequest)
               state_nxt = S_EXEC1;
         end
         S_EXEC1: begin
            ir_nxt    = mem_readdata;
            state_nxt = S_EXEC2;
         end
         S_EXEC2: begin
            if (!stall) begin
               commit = 1'b1;
               pc_nxt = commit_pc;
               if (pend_vld) begin
                  pend_vld_nxt = 1'b0;
               end else if (branch_taken) begin
                  pend_vld_nxt    = 1'b1;
                  pend_target_nxt = branch_target;
               end
               state_nxt = (commit_pc == HALT_ADDR) ? S_HALTED : S_FETCH;
            end
         end
         S_HALTED: begin
         end
      endcase
   end

   assign fetch               = (state == S_FETCH);
   assign exec1               = (state == S_EXEC1);
   assign exec2               = (state == S_EXEC2);
   assign active              = (state != S_HALTED);
   assign mem_read            = fetch;
   assign mem_address         = pc;
   assign current_instruction = exec1 ? mem_readdata : ir;

`ifdef FETCH_SEQ_RETIRE_COUNT_EN
   always_ff @(posedge clk) begin
      if (!reset_n)
         retired_count <= 32'd0;
      else if (commit)
         retired_count <= retired_count + 32'd1;
   end
`else
   logic unused_commit;
   assign unused_commit = commit;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected fetch addresses are queued per scenario and checked as instructions flow.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        mem_waitrequest;
   logic [31:0] mem_readdata;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        mem_read;
   logic [31:0] mem_address;
   logic [31:0] current_instruction;
   logic        fetch, exec1, exec2;
   logic [31:0] pc;
   logic        active;
`ifdef FETCH_SEQ_RETIRE_COUNT_EN
   logic [31:0] retired_count;
`endif

   int vec  = 0;
   int errs = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   fetch_sequencer dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .mem_waitrequest     (mem_waitrequest),
      .mem_readdata        (mem_readdata),
      .stall               (stall),
      .branch_taken        (branch_taken),
      .branch_target       (branch_target),
      .mem_read            (mem_read),
      .mem_address         (mem_address),
      .current_instruction (current_instruction),
      .fetch               (fetch),
      .exec1               (exec1),
      .exec2               (exec2),
      .pc                  (pc),
      .active              (active)
`ifdef FETCH_SEQ_RETIRE_COUNT_EN
      ,
      .retired_count       (retired_count)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'hBFC00000) return 32'h24020005;
      return a ^ 32'hA5A50000;
   endfunction

   // Instruction memory answers whatever address is on the bus.
   assign mem_readdata = mem_word(mem_address);

   // Every task starts and ends just after a rising edge.
   task automatic do_reset();
      reset_n = 1'b0; mem_waitrequest = 1'b1; stall = 1'b0;
      branch_taken = 1'b0; branch_target = 32'd0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      exp_q.delete();
   endtask

   task automatic run_instr(input int waits, input int stalls, input logic br, input logic [31:0] tgt);
      logic [31:0] ea, ei;
      if (exp_q.size() == 0) begin
         vec++; errs++;
         $display("FAIL sb_empty: no expected address queued, actual pc=%h", pc);
         ea = 32'hXXXXXXXX;
      end else begin
         ea = exp_q.pop_front();
      end
      ei = mem_word(ea);
      for (int w = 0; w <= waits; w++) begin
         mem_waitrequest = (w < waits); stall = 1'b0; branch_taken = 1'b0;
         @(negedge clk);
         vec++;
         if ({fetch, exec1, exec2, mem_read} !== 4'b1001 || mem_address !== ea || pc !== ea) begin
            errs++;
            $display("FAIL fetch_phase w=%0d: got f/e1/e2/rd=%b%b%b%b addr=%h pc=%h, want 1001 addr=%h",
                     w, fetch, exec1, exec2, mem_read, mem_address, pc, ea);
         end
         @(posedge clk); #1;
      end
      mem_waitrequest = 1'b0;
      @(negedge clk);
      vec++;
      if ({fetch, exec1, exec2, mem_read} !== 4'b0100 || current_instruction !== ei) begin
         errs++;
         $display("FAIL exec1_phase: got f/e1/e2/rd=%b%b%b%b instr=%h, want 0100 instr=%h",
                  fetch, exec1, exec2, mem_read, current_instruction, ei);
      end
      @(posedge clk); #1;
      for (int s = 0; s <= stalls; s++) begin
         stall         = (s < stalls);
         branch_taken  = (s < stalls) ? ~s[0] : br;
         branch_target = (s < stalls) ? 32'hDEAD0000 : tgt;
         @(negedge clk);
         vec++;
         if ({fetch, exec1, exec2, mem_read} !== 4'b0010 || current_instruction !== ei || pc !== ea) begin
            errs++;
            $display("FAIL exec2_phase s=%0d: got f/e1/e2/rd=%b%b%b%b instr=%h pc=%h, want 0010 instr=%h pc=%h",
                     s, fetch, exec1, exec2, mem_read, current_instruction, pc, ei, ea);
         end
         @(posedge clk); #1;
      end
      stall = 1'b0; branch_taken = 1'b0;
   endtask

   task automatic check_halted(input int cycles, input logic [31:0] last_instr);
      for (int c = 0; c < cycles; c++) begin
         mem_waitrequest = 1'b0;
         @(negedge clk);
         vec++;
         if ({fetch, exec1, exec2, mem_read, active} !== 5'b00000 || pc !== 32'd0 ||
             mem_address !== 32'd0 || current_instruction !== last_instr) begin
            errs++;
            $display("FAIL halted c=%0d: got f/e1/e2/rd/act=%b%b%b%b%b pc=%h instr=%h, want 00000 pc=0 instr=%h",
                     c, fetch, exec1, exec2, mem_read, active, pc, current_instruction, last_instr);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      vec++;
      if ({fetch, exec1, exec2, mem_read, active} !== 5'b10011 || mem_address !== 32'hBFC00000 ||
          pc !== 32'hBFC00000 || current_instruction !== 32'd0) begin
         errs++;
         $display("FAIL reset_state: got f/e1/e2/rd/act=%b%b%b%b%b addr=%h pc=%h instr=%h, want 10011 BFC00000 BFC00000 0",
                  fetch, exec1, exec2, mem_read, active, mem_address, pc, current_instruction);
      end
`ifdef FETCH_SEQ_RETIRE_COUNT_EN
      vec++;
      if (retired_count !== 32'd0) begin
         errs++;
         $display("FAIL reset_count: got %0d want 0", retired_count);
      end
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      exp_q.push_back(32'hBFC00000);
      run_instr(0, 0, 1'b0, 32'd0);
   endtask

   task automatic test_waitrequest();
      exp_q.push_back(32'hBFC00004);
      run_instr(3, 0, 1'b0, 32'd0);
   endtask

   task automatic test_branch();
      exp_q.push_back(32'hBFC00008);
      run_instr(0, 0, 1'b1, 32'hBFC00100);
      exp_q.push_back(32'hBFC0000C);
      run_instr(1, 0, 1'b1, 32'hBFC00800);   // branch in delay slot must be ignored
      exp_q.push_back(32'hBFC00100);
   endtask

   task automatic test_stall();
      run_instr(0, 5, 1'b1, 32'hBFC00200);
      exp_q.push_back(32'hBFC00104);
      run_instr(0, 2, 1'b0, 32'd0);
      exp_q.push_back(32'hBFC00200);
   endtask

   task automatic test_reset_mid();
      run_instr(0, 0, 1'b1, 32'hBFC00300);
      // Delay-slot instruction, reset during its (stalled) EXEC2.
      mem_waitrequest = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      stall = 1'b1; reset_n = 1'b0; mem_waitrequest = 1'b1;
      @(posedge clk); #1;
      reset_n = 1'b1; stall = 1'b0;
      @(negedge clk);
      vec++;
      if ({fetch, exec1, exec2, active} !== 4'b1001 || pc !== 32'hBFC00000) begin
         errs++;
         $display("FAIL reset_mid: got f/e1/e2/act=%b%b%b%b pc=%h, want 1001 BFC00000",
                  fetch, exec1, exec2, active, pc);
      end
      @(posedge clk); #1;
      exp_q.delete();
      exp_q.push_back(32'hBFC00000);
      run_instr(0, 0, 1'b0, 32'd0);
      exp_q.push_back(32'hBFC00004);
      run_instr(0, 0, 1'b0, 32'd0);
      exp_q.push_back(32'hBFC00008);
      run_instr(0, 0, 1'b0, 32'd0);
   endtask

   task automatic test_halt();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(32'hBFC00000 + 32'(i * 4));
         run_instr(0, 0, 1'b0, 32'd0);
      end
      exp_q.push_back(32'hBFC00010);
      run_instr(0, 0, 1'b1, 32'd0);
      exp_q.push_back(32'hBFC00014);
      run_instr(0, 1, 1'b0, 32'd0);
      check_halted(12, mem_word(32'hBFC00014));
`ifdef FETCH_SEQ_RETIRE_COUNT_EN
      vec++;
      if (retired_count !== 32'd6) begin
         errs++;
         $display("FAIL halt_count: got %0d want 6", retired_count);
      end
`endif
   endtask

   task automatic test_wrap_halt();
      do_reset();
      exp_q.push_back(32'hBFC00000);
      run_instr(0, 0, 1'b1, 32'hFFFFFFF8);
      exp_q.push_back(32'hBFC00004);
      run_instr(0, 0, 1'b0, 32'd0);
      exp_q.push_back(32'hFFFFFFF8);
      run_instr(0, 0, 1'b0, 32'd0);
      exp_q.push_back(32'hFFFFFFFC);
      run_instr(0, 0, 1'b0, 32'd0);
      check_halted(4, mem_word(32'hFFFFFFFC));
`ifdef FETCH_SEQ_RETIRE_COUNT_EN
      vec++;
      if (retired_count !== 32'd4) begin
         errs++;
         $display("FAIL wrap_count: got %0d want 4", retired_count);
      end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0; mem_waitrequest = 1'b1; stall = 1'b0;
      branch_taken = 1'b0; branch_target = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_waitrequest();
      test_branch();
      test_stall();
      test_reset_mid();
      test_halt();
      test_wrap_halt();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
